// File: rtl/router_pkg.sv
// router_pkg: shared state encoding, header field positions and invalid-destination code for the router input stage
package router_pkg;
  typedef enum logic [1:0] {IDLE, PAYLOAD, DROP, CHECK} state_t;
  localparam logic [1:0] ADDR_INVALID = 2'b11;
  localparam int LEN_W = 6;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;
  localparam int DEST_MSB = 1;
  localparam int DEST_LSB = 0;
endpackage

// File: rtl/router_in_fsm.sv
// router_in_fsm: packet sequencing FSM (IDLE/PAYLOAD/DROP/CHECK) with a registered one-cycle pkt_done pulse
// Ports: clock, resetn (async active-low), acc (byte accepted this edge), pkt_valid,
//        hdr_invalid (incoming header targets destination 3), drained (hold empty after this edge),
//        state (current state), pkt_done (high for the single cycle after the parity byte is accepted)
module router_in_fsm
  import router_pkg::*;
(
  input  logic   clock,
  input  logic   resetn,
  input  logic   acc,
  input  logic   pkt_valid,
  input  logic   hdr_invalid,
  input  logic   drained,
  output state_t state,
  output logic   pkt_done
);
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: if (acc) state <= hdr_invalid ? DROP : PAYLOAD;
        PAYLOAD, DROP: if (acc && !pkt_valid) begin
          state <= CHECK;
          pkt_done <= 1'b1;
        end
        CHECK: if (drained) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/router_input_stage.sv
// router_input_stage: accepts header/payload/parity byte stream, forwards it through a one-byte hold to one of three FIFOs, flags packet errors
// Ports: clock, resetn (async active-low), data_in[7:0], pkt_valid, fifo_full[2:0] in;
//        busy, err, dout[7:0], write_enb[2:0] (one-hot), pkt_done out.
// Macro ROUTER_LEN_CHECK_EN: when defined, a payload count differing from the header length also sets err.
module router_input_stage
  import router_pkg::*;
#(
  parameter int NUM_DEST = 3
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [7:0]          data_in,
  input  logic                pkt_valid,
  input  logic [NUM_DEST-1:0] fifo_full,
  output logic                busy,
  output logic                err,
  output logic [7:0]          dout,
  output logic [NUM_DEST-1:0] write_enb,
  output logic                pkt_done
);
  state_t state;
  logic [7:0] hold, parity;
  logic hold_valid;
  logic [1:0] dest;
  logic [3:0] full_vec;
  logic full, acc, hdr, par_byte, pay, ld, wr, hdr_invalid, len_err;
  assign full_vec = 4'(fifo_full);
  assign full = full_vec[dest];
  assign hdr_invalid = data_in[DEST_MSB:DEST_LSB] == ADDR_INVALID;
  assign busy = (hold_valid & full) | (state == CHECK);
  assign acc = ~busy & ((state == IDLE & pkt_valid) | state == PAYLOAD | state == DROP);
  assign hdr = acc & state == IDLE;
  assign par_byte = acc & ~pkt_valid;
  assign pay = acc & pkt_valid & state == PAYLOAD;
  // a header for destination 3 is never staged, so the hold only ever carries writable bytes
  assign ld = acc & (state == PAYLOAD | (state == IDLE & ~hdr_invalid));
  assign wr = hold_valid & ~full;
  assign dout = hold;
  assign write_enb = wr ? NUM_DEST'(1) << dest : '0;
`ifdef ROUTER_LEN_CHECK_EN
  logic [LEN_W-1:0] len, count;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      len <= '0;
      count <= '0;
    end else if (hdr) begin
      len <= data_in[LEN_MSB:LEN_LSB];
      count <= '0;
    end else if (pay && count != '1) count <= count + LEN_W'(1);
  assign len_err = count != len;
`else
  assign len_err = 1'b0;
`endif
  router_in_fsm u_fsm (
    .clock(clock),
    .resetn(resetn),
    .acc(acc),
    .pkt_valid(pkt_valid),
    .hdr_invalid(hdr_invalid),
    .drained(~hold_valid | wr),
    .state(state),
    .pkt_done(pkt_done)
  );
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      hold <= '0;
      hold_valid <= 1'b0;
      parity <= '0;
      dest <= '0;
      err <= 1'b0;
    end else begin
      if (ld) hold <= data_in;
      hold_valid <= ld | (hold_valid & ~wr);
      if (hdr) begin
        dest <= data_in[DEST_MSB:DEST_LSB];
        parity <= data_in;
        err <= 1'b0;
      end else if (par_byte) err <= (data_in != parity) | (dest == ADDR_INVALID) | len_err;
      else if (pay) parity <= parity ^ data_in;
    end
endmodule
